// File: rtl/pe_in_feeder_if.sv
// Command, SRAM-read and FIFO-push signals of the PE input feeder.
// master is the controller/environment side; slave is the feeder itself.
interface pe_in_feeder_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 8
);
  logic               start;
  logic [AW-1:0]      base_addr;
  logic [AW-1:0]      num_words;
  logic               busy;
  logic               done;
  logic               mem_rd_en;
  logic [AW-1:0]      mem_addr;
  logic [4*WIDTH-1:0] mem_rdata;
  logic               fifo_psh;
  logic [4*WIDTH-1:0] fifo_din;
  logic [1:0]         fifo_pop;
  logic               err;

  modport master (
    output start, base_addr, num_words, mem_rdata, fifo_pop,
    input  busy, done, mem_rd_en, mem_addr, fifo_psh, fifo_din, err
  );

  modport slave (
    input  start, base_addr, num_words, mem_rdata, fifo_pop,
    output busy, done, mem_rd_en, mem_addr, fifo_psh, fifo_din, err
  );
endinterface

// File: rtl/pe_in_feeder.sv
// Streams a block of 4-element words from local SRAM into a PE input FIFO.
// The FIFO has no full flag, so occupancy is tracked here from the pop bus
// and a read is only issued when its word is guaranteed to fit.
//
// state | meaning
// IDLE  | waiting for start; occupancy still tracks consumer pops
// RUN   | issuing SRAM reads as credit allows
// DRAIN | all reads issued, waiting for the last push
// FIN   | one-cycle done pulse
module pe_in_feeder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int AW    = 8
) (
  input logic           clk,
  input logic           rst_n,
  pe_in_feeder_if.slave bus
);
  localparam int CAP = 4 * DEPTH;
  localparam int OW  = $clog2(CAP) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      addr, remaining;
  logic [OW-1:0]      occ, occ_nxt;
  logic [OW+1:0]      need;
  logic               inflight, psh_q, err_q;
  logic               issue, load;
  logic [1:0]         pop_val;
  logic               pop_bad, underflow;
  logic [4*WIDTH-1:0] din_gated;

  // Credit check uses registered occ/inflight only; same-cycle pops are not
  // credited until they land in occ.
  assign need  = (OW+2)'(occ) + (inflight ? (OW+2)'(8) : (OW+2)'(4));
  assign issue = (state == RUN) && (remaining != '0) && (need <= (OW+2)'(CAP));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and command latch strobe.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = (bus.num_words == '0) ? FIN : RUN;
        end
      end
      RUN:     if (issue && remaining == AW'(1)) state_nxt = DRAIN;
      DRAIN:   if (!inflight) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decode the FIFO pop bus; 2'b11 is illegal and contributes no pop.
  always_comb begin
    pop_val = 2'd0;
    pop_bad = 1'b0;
    case (bus.fifo_pop)
      2'b01:   pop_val = 2'd1;
      2'b10:   pop_val = 2'd2;
      2'b11:   pop_bad = 1'b1;
      default: pop_val = 2'd0;
    endcase
    underflow = OW'(pop_val) > occ;
    if (underflow) occ_nxt = psh_q ? OW'(4) : '0;
    else           occ_nxt = occ + (psh_q ? OW'(4) : '0) - OW'(pop_val);
  end

  // Address/count, credit tracking, push pipeline and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      occ       <= '0;
      inflight  <= 1'b0;
      psh_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (load) begin
        addr      <= bus.base_addr;
        remaining <= bus.num_words;
      end else if (issue) begin
        addr      <= addr + AW'(1);
        remaining <= remaining - AW'(1);
      end
      // Issue wins over a same-cycle push: the new read is still in flight.
      if (issue)      inflight <= 1'b1;
      else if (psh_q) inflight <= 1'b0;
      psh_q <= issue;
      occ   <= occ_nxt;
      if (pop_bad || underflow) err_q <= 1'b1;
    end
  end

  assign din_gated = psh_q ? bus.mem_rdata : '0;

  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == FIN);
  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = issue ? addr : '0;
  assign bus.fifo_psh  = psh_q;
  assign bus.fifo_din  = din_gated;
  assign bus.err       = err_q;

  occ_in_range: assert property (@(posedge clk) disable iff (!rst_n) occ <= OW'(CAP));
endmodule

// File: tb/tb_pe_in_feeder.sv
// Directed bench for pe_in_feeder (WIDTH=4, DEPTH=2, AW=8).
module tb_pe_in_feeder;
  logic clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  pe_in_feeder_if #(.WIDTH(4), .AW(8)) bus();

  pe_in_feeder #(.WIDTH(4), .DEPTH(2), .AW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a[3:0] ^ 4'h5, ~a[3:0], a[7:4], a[3:0] + 4'd3};
  endfunction

  // SRAM model: data valid exactly one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= pat(bus.mem_addr);
    else               bus.mem_rdata <= 16'h0000;
  end

  logic [7:0]  rd_q[$];
  logic [15:0] psh_q[$];
  bit          done_seen;
  bit          auto_pop;
  int          occ_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.fifo_pop  = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    rd_q.delete();
    psh_q.delete();
    done_seen = 1'b0;
  endtask

  // Free-runs the transfer, logging reads/pushes; optionally pops 2 per cycle
  // whenever the modelled occupancy allows it.
  task automatic run_loop(input int max_cyc);
    logic [1:0] pop;
    int cyc = 0;
    while (!done_seen && cyc < max_cyc) begin
      if (bus.mem_rd_en) rd_q.push_back(bus.mem_addr);
      if (bus.fifo_psh)  psh_q.push_back(bus.fifo_din);
      if (bus.done)      done_seen = 1'b1;
      pop = (auto_pop && occ_m >= 2) ? 2'b10 : 2'b00;
      bus.fifo_pop = pop;
      occ_m = occ_m + (bus.fifo_psh ? 4 : 0) - ((pop == 2'b10) ? 2 : 0);
      tick();
      cyc++;
    end
    bus.fifo_pop = 2'b00;
  endtask

  task automatic start_cmd(input logic [7:0] base, input logic [7:0] nw);
    bus.base_addr = base;
    bus.num_words = nw;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", bus.mem_rd_en); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus.mem_addr); end
    checks++; if (bus.fifo_psh !== 1'b0) begin errors++; $display("FAIL reset_psh got %b exp 0", bus.fifo_psh); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
    checks++; if (dut.occ !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", dut.occ); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    start_cmd(8'h10, 8'd2);
    // W1: first read
    checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 8'h10) begin errors++; $display("FAIL basic_rd0 got en=%b addr=%h exp en=1 addr=10", bus.mem_rd_en, bus.mem_addr); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", bus.busy); end
    tick();
    checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 8'h11) begin errors++; $display("FAIL basic_rd1 got en=%b addr=%h exp en=1 addr=11", bus.mem_rd_en, bus.mem_addr); end
    checks++; if (bus.fifo_psh !== 1'b1 || bus.fifo_din !== pat(8'h10)) begin errors++; $display("FAIL basic_psh0 got psh=%b din=%h exp psh=1 din=%h", bus.fifo_psh, bus.fifo_din, pat(8'h10)); end
    tick();
    checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL basic_rd_stop got %b exp 0", bus.mem_rd_en); end
    checks++; if (bus.fifo_psh !== 1'b1 || bus.fifo_din !== pat(8'h11)) begin errors++; $display("FAIL basic_psh1 got psh=%b din=%h exp psh=1 din=%h", bus.fifo_psh, bus.fifo_din, pat(8'h11)); end
    tick();
    checks++; if (bus.fifo_psh !== 1'b0 || bus.fifo_din !== 16'h0) begin errors++; $display("FAIL basic_din_gate got psh=%b din=%h exp 0/0000", bus.fifo_psh, bus.fifo_din); end
    checks++; if (dut.occ !== 4'd8) begin errors++; $display("FAIL basic_occ got %0d exp 8", dut.occ); end
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_drain got done=%b busy=%b exp 0/1", bus.done, bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_done got done=%b busy=%b exp 1/0", bus.done, bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", bus.done); end
    bus.fifo_pop = 2'b01;
    tick();
    bus.fifo_pop = 2'b00;
    checks++; if (dut.occ !== 4'd7) begin errors++; $display("FAIL basic_idle_pop got %0d exp 7", dut.occ); end
  endtask

  task automatic test_stall();
    do_reset();
    start_cmd(8'h10, 8'd5);
    tick();
    tick();
    checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL stall_w3 got %b exp 0", bus.mem_rd_en); end
    tick();
    checks++; if (bus.mem_rd_en !== 1'b0 || dut.occ !== 4'd8) begin errors++; $display("FAIL stall_w4 got en=%b occ=%0d exp 0/8", bus.mem_rd_en, dut.occ); end
    bus.fifo_pop = 2'b10;
    tick();
    checks++; if (bus.mem_rd_en !== 1'b0 || dut.occ !== 4'd6) begin errors++; $display("FAIL stall_occ6 got en=%b occ=%0d exp 0/6", bus.mem_rd_en, dut.occ); end
    tick();
    bus.fifo_pop = 2'b00;
    checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 8'h12 || dut.occ !== 4'd4) begin errors++; $display("FAIL stall_resume got en=%b addr=%h occ=%0d exp 1/12/4", bus.mem_rd_en, bus.mem_addr, dut.occ); end
    clear_log();
    auto_pop = 1'b1;
    occ_m    = 4;
    run_loop(80);
    auto_pop = 1'b0;
    checks++; if (!done_seen) begin errors++; $display("FAIL stall_done got none exp pulse within 80 cycles"); end
    checks++; if (rd_q.size() != 3) begin errors++; $display("FAIL stall_nrd got %0d exp 3", rd_q.size()); end
    checks++; if (psh_q.size() != 3) begin errors++; $display("FAIL stall_npsh got %0d exp 3", psh_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (((i < psh_q.size()) ? psh_q[i] : 16'hxxxx) !== pat(8'h12 + 8'(i))) begin
        errors++; $display("FAIL stall_data%0d got %h exp %h", i, (i < psh_q.size()) ? psh_q[i] : 16'hxxxx, pat(8'h12 + 8'(i)));
      end
    end
    checks++; if (bus.err !== 1'b0 || dut.occ !== 4'(occ_m)) begin errors++; $display("FAIL stall_end got err=%b occ=%0d exp 0/%0d", bus.err, dut.occ, occ_m); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a[3];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
    do_reset();
    clear_log();
    start_cmd(8'hFE, 8'd3);
    auto_pop = 1'b1;
    occ_m    = 0;
    run_loop(80);
    auto_pop = 1'b0;
    checks++; if (!done_seen || rd_q.size() != 3) begin errors++; $display("FAIL wrap_count got done=%b nrd=%0d exp 1/3", done_seen, rd_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (((i < rd_q.size()) ? rd_q[i] : 8'hxx) !== exp_a[i]) begin
        errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, (i < rd_q.size()) ? rd_q[i] : 8'hxx, exp_a[i]);
      end
      checks++;
      if (((i < psh_q.size()) ? psh_q[i] : 16'hxxxx) !== pat(exp_a[i])) begin
        errors++; $display("FAIL wrap_data%0d got %h exp %h", i, (i < psh_q.size()) ? psh_q[i] : 16'hxxxx, pat(exp_a[i]));
      end
    end
  endtask

  task automatic test_zero();
    int n_done = 0;
    bit rd_seen = 0, busy_seen = 0;
    do_reset();
    start_cmd(8'h33, 8'd0);
    for (int i = 0; i < 4; i++) begin
      if (bus.done)      n_done++;
      if (bus.mem_rd_en) rd_seen = 1;
      if (bus.busy)      busy_seen = 1;
      tick();
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL zero_done got %0d pulses exp 1", n_done); end
    checks++; if (rd_seen || busy_seen) begin errors++; $display("FAIL zero_idle got rd=%b busy=%b exp 0/0", rd_seen, busy_seen); end
  endtask

  task automatic test_errors();
    do_reset();
    clear_log();
    start_cmd(8'h50, 8'd1);
    occ_m = 0;
    run_loop(20);
    bus.fifo_pop = 2'b01;
    tick(); tick(); tick();
    bus.fifo_pop = 2'b00;
    checks++; if (dut.occ !== 4'd1 || bus.err !== 1'b0) begin errors++; $display("FAIL err_setup got occ=%0d err=%b exp 1/0", dut.occ, bus.err); end
    bus.fifo_pop = 2'b11;
    tick();
    bus.fifo_pop = 2'b00;
    checks++; if (bus.err !== 1'b1 || dut.occ !== 4'd1) begin errors++; $display("FAIL err_pop11 got err=%b occ=%0d exp 1/1", bus.err, dut.occ); end
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus.err); end
    do_reset();
    clear_log();
    start_cmd(8'h50, 8'd1);
    occ_m = 0;
    run_loop(20);
    bus.fifo_pop = 2'b01;
    tick(); tick(); tick();
    bus.fifo_pop = 2'b10;
    tick();
    bus.fifo_pop = 2'b00;
    checks++; if (bus.err !== 1'b1 || dut.occ !== 4'd0) begin errors++; $display("FAIL err_underflow got err=%b occ=%0d exp 1/0", bus.err, dut.occ); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_cmd(8'h10, 8'd5);
    tick();
    tick();
    checks++; if (dut.remaining !== 8'd3 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_setup got rem=%0d busy=%b exp 3/1", dut.remaining, bus.busy); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 8'h00 ||
        bus.fifo_psh !== 1'b0 || bus.fifo_din !== 16'h0 || bus.err !== 1'b0 || dut.occ !== 4'd0) begin
      errors++; $display("FAIL mid_reset got busy=%b done=%b en=%b addr=%h psh=%b din=%h err=%b occ=%0d exp all 0",
        bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr, bus.fifo_psh, bus.fifo_din, bus.err, dut.occ);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_no_done got done=%b busy=%b exp 0/0", bus.done, bus.busy); end
    clear_log();
    start_cmd(8'h40, 8'd1);
    occ_m = 0;
    run_loop(20);
    checks++; if (!done_seen || rd_q.size() != 1 || psh_q.size() != 1) begin errors++; $display("FAIL mid_restart got done=%b nrd=%0d npsh=%0d exp 1/1/1", done_seen, rd_q.size(), psh_q.size()); end
    checks++; if (((psh_q.size() > 0) ? psh_q[0] : 16'hxxxx) !== pat(8'h40)) begin errors++; $display("FAIL mid_restart_data got %h exp %h", (psh_q.size() > 0) ? psh_q[0] : 16'hxxxx, pat(8'h40)); end
  endtask

  task automatic test_start_ignore();
    bit late = 0;
    do_reset();
    clear_log();
    start_cmd(8'h20, 8'd2);
    bus.base_addr = 8'h80;
    bus.num_words = 8'd3;
    bus.start     = 1'b1;
    occ_m = 0;
    run_loop(1);
    bus.start = 1'b0;
    run_loop(40);
    checks++; if (!done_seen || rd_q.size() != 2) begin errors++; $display("FAIL ign_count got done=%b nrd=%0d exp 1/2", done_seen, rd_q.size()); end
    checks++; if (((rd_q.size() > 1) ? rd_q[1] : 8'hxx) !== 8'h21) begin errors++; $display("FAIL ign_addr got %h exp 21", (rd_q.size() > 1) ? rd_q[1] : 8'hxx); end
    for (int i = 0; i < 4; i++) begin
      if (bus.busy || bus.mem_rd_en) late = 1;
      tick();
    end
    checks++; if (late) begin errors++; $display("FAIL ign_after got activity=1 exp 0"); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = 8'h00;
    bus.num_words = 8'h00;
    bus.fifo_pop  = 2'b00;
    auto_pop      = 1'b0;
    occ_m         = 0;
    done_seen     = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero();
    test_errors();
    test_reset_mid();
    test_start_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
